ks_byte_serial_add_sequencer: RTL and testbench

//  Sequences one shared 8-bit Kogge-Stone adder slice to form WIDTH-bit add/subtract results
//  one byte per cycle, LS byte first, with the carry chained between passes.

---
 rtl/ks_byte_serial_add_sequencer.sv | 154 +++++++++++++++
 tb/tb_ks_byte_serial_add_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ks_byte_serial_add_sequencer.sv
// Byte-serial WIDTH-bit add/sub over one shared 8-bit adder slice; accept edge to out_valid = NSLICE+1 edges.
// Busy ops are refused (in_ready=0); DONE holds the result stable until out_ready. Optional: KS_SEQ_SAT_EN.
module ks_byte_serial_add_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic [7:0]       add_a,
  output logic [7:0]       add_b,
  output logic             add_cin,
  input  logic [7:0]       add_s,
  input  logic             add_cout,
  input  logic             add_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             res_cout,
  output logic             res_ovf,
  output logic             res_zero
);

  // WIDTH must be a multiple of 8 and at least 16.
  localparam int NSLICE = WIDTH / 8;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             alive_q;
  logic             accept;
  logic             pass;
  logic             last_pass;
  logic             retire;
  logic [WIDTH-1:0] res_asm;
  logic [WIDTH-1:0] res_fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Keeps in_ready low through reset and until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q <= 1'b0;
    end else begin
      alive_q <= 1'b1;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = 8'h00;
    add_b     = 8'h00;
    add_cin   = 1'b0;
    accept    = 1'b0;
    pass      = 1'b0;
    last_pass = 1'b0;
    retire    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = alive_q;
        if (in_valid && alive_q) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        add_a   = a_q[int'(cnt_q)*8 +: 8];
        add_b   = b_q[int'(cnt_q)*8 +: 8];
        add_cin = carry_q;
        pass    = 1'b1;
        if (cnt_q == LAST) begin
          last_pass = 1'b1;
          state_nx  = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          retire   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Full result as it will look once the current byte lands; needed for the zero flag on the final pass.
  always_comb begin
    res_asm = res;
    res_asm[int'(cnt_q)*8 +: 8] = add_s;
    res_fin = res_asm;
`ifdef KS_SEQ_SAT_EN
    if (add_ovf) begin
      res_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      res      <= '0;
      res_cout <= 1'b0;
      res_ovf  <= 1'b0;
      res_zero <= 1'b0;
    end else if (accept) begin
      a_q     <= op_a;
      b_q     <= op_b ^ {WIDTH{op_sub}};
      carry_q <= op_sub;
      cnt_q   <= '0;
    end else if (pass) begin
      carry_q <= add_cout;
      if (last_pass) begin
        // Counter holds at the last slice; it is cleared on leaving DONE.
        res      <= res_fin;
        res_cout <= add_cout;
        res_ovf  <= add_ovf;
        res_zero <= ~|res_fin;
      end else begin
        res   <= res_asm;
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (retire) begin
      cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_ks_byte_serial_add_sequencer.sv
// Directed bench for ks_byte_serial_add_sequencer with a behavioural 8-bit adder slice.
module tb_ks_byte_serial_add_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_sub;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_cin;
  logic [7:0]  add_s;
  logic        add_cout;
  logic        add_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        res_cout;
  logic        res_ovf;
  logic        res_zero;

  int tests = 0;
  int fails = 0;

  ks_byte_serial_add_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout), .add_ovf(add_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .res_cout(res_cout), .res_ovf(res_ovf), .res_zero(res_zero)
  );

  // Combinational adder slice standing in for the shared Kogge-Stone instance.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};
  assign add_ovf = (add_a[7] == add_b[7]) && (add_s[7] != add_a[7]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offers an op, checks first-pass adder drive and latency, and leaves the sequencer in DONE.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [31:0] e_res, input logic e_cout, input logic e_ovf, input logic e_zero);
    logic [31:0] bx;
    int n;
    bx = b ^ {32{sub}};
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    op_sub = sub;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op_a = 32'h0;
    op_b = 32'h0;
    op_sub = 1'b0;
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
    chk({tag, "_adda0"}, 32'(add_a), 32'(a[7:0]));
    chk({tag, "_addb0"}, 32'(add_b), 32'(bx[7:0]));
    chk({tag, "_cin0"}, 32'(add_cin), 32'(sub));
    repeat (3) @(negedge clk);
    chk({tag, "_vld_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_res"}, res, e_res);
    chk({tag, "_cout"}, 32'(res_cout), 32'(e_cout));
    chk({tag, "_ovf"}, 32'(res_ovf), 32'(e_ovf));
    chk({tag, "_zero"}, 32'(res_zero), 32'(e_zero));
    chk({tag, "_quiet"}, {23'h0, add_cin, add_a}, 32'h0);
  endtask

  task automatic retire_op(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] sat_exp;
    logic [31:0] sat_exp2;
    int seen;
    rst_n = 1'b0;
    in_valid = 1'b0;
    op_a = 32'h0;
    op_b = 32'h0;
    op_sub = 1'b0;
    out_ready = 1'b0;
`ifdef KS_SEQ_SAT_EN
    sat_exp  = 32'h7FFF_FFFF;
    sat_exp2 = 32'h8000_0000;
`else
    sat_exp  = 32'h8000_0000;
    sat_exp2 = 32'h7FFF_FFFF;
`endif

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_res", res, 32'h0);
    chk("rst_flags", {29'h0, res_cout, res_ovf, res_zero}, 32'h0);
    chk("rst_adder", {15'h0, add_cin, add_a, add_b}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    run_op("add_ff_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    retire_op("add_ff_1");
    run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    retire_op("add_wrap");
    run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, sat_exp, 1'b0, 1'b1, 1'b0);
    retire_op("add_ovf");
    run_op("sub_5_7", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    retire_op("sub_5_7");
    run_op("sub_7_5", 32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);

    // Back-pressure: DONE held with a competing request pending.
    in_valid = 1'b1;
    op_a = 32'h1234_5678;
    op_b = 32'h1111_1111;
    op_sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_res", res, 32'h0000_0002);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    retire_op("bp");
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    run_op("bp_second", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    retire_op("bp_second");

    // Reset asserted during the second RUN pass.
    in_valid = 1'b1;
    op_a = 32'h0101_0101;
    op_b = 32'h0202_0202;
    op_sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_run_pass2", 32'(add_a), 32'h01);
    rst_n = 1'b0;
    #1;
    chk("mrst_res", res, 32'h0);
    chk("mrst_outs", {28'h0, out_valid, in_ready, add_cin, res_zero}, 32'h0);
    chk("mrst_adder", {16'h0, add_a, add_b}, 32'h0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mrst_no_valid", 32'(seen), 32'd0);
    chk("mrst_idle_ready", 32'(in_ready), 32'd1);
    run_op("post_rst", 32'h8000_0000, 32'h0000_0001, 1'b1, sat_exp2, 1'b1, 1'b1, 1'b0);
    retire_op("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
